// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store path and a host port
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_CORE = 2'd1;
    localparam logic [1:0] RD_HOST = 2'd2;

    logic [1:0] state;
    logic [7:0] starve_cnt;
    logic       host_win, core_win, rd_core, rd_host;

    // Same-cycle arbitration in IDLE; everything is gated while reset is held low
    always_comb begin
        host_win = reset && state == IDLE && host_req && (!core_req || starve_cnt == 8'(STARVE_LIMIT));
        core_win = reset && state == IDLE && core_req && !host_win;
        rd_core  = reset && state == RD_CORE;
        rd_host  = reset && state == RD_HOST;
    end

    assign mem_en     = host_win || core_win;
    assign mem_we     = host_win ? host_we    : core_win ? core_we    : 1'b0;
    assign mem_addr   = host_win ? host_addr  : core_win ? core_addr  : '0;
    assign mem_wdata  = host_win ? host_wdata : core_win ? core_wdata : '0;
    assign core_ack   = (core_win && core_we) || rd_core;
    assign host_ack   = (host_win && host_we) || rd_host;
    assign core_rdata = rd_core ? mem_rdata : '0;
    assign host_rdata = rd_host ? mem_rdata : '0;
    assign core_stall = reset && core_req && !core_ack;
    assign busy       = state != IDLE;

    // Reads park in RD_* for the data-return cycle; writes stay in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= host_win ? (host_we ? IDLE : RD_HOST) : core_win ? (core_we ? IDLE : RD_CORE) : IDLE;
    end

    // Counts core grants made while the host waits, saturating at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!host_req || host_win)
            starve_cnt <= '0;
        else if (core_win && starve_cnt != 8'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, host_req, host_we;
    logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
    logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_ack, core_stall, host_ack, mem_en, mem_we, busy;

    typedef struct packed {
        logic        host;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mem[256];
    bit          wr[256];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return a == 8'h20 ? 32'h1234 : a == 8'h40 ? 32'hBEEF : a == 8'h24 ? 32'h5678 : {24'hDEAD00, a};
    endfunction

    // Memory with one-cycle read latency; unwritten words return a fixed pattern
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr[mem_addr[7:0]]  <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] all_out();
        return {mem_en, mem_we, mem_addr, mem_wdata, core_ack, core_stall, host_ack, busy, core_rdata, host_rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic host, input logic [31:0] data);
        exp_q.push_back('{host: host, data: data});
    endtask

    // Scoreboard: every ack pops the oldest expected transaction
    always @(negedge clk) begin
        if (core_ack || host_ack) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_ack", {core_ack, host_ack}, 2'b00);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_src", {core_ack, host_ack}, {!e.host, e.host});
                chk("sb_rdata", host_ack ? host_rdata : core_rdata, e.data);
            end
        end else
            chk("rdata_idle", {core_rdata, host_rdata}, 64'h0);
    end

    initial begin
        reset = 1'b0;
        {core_req, core_we, host_req, host_we} = '0;
        {core_addr, core_wdata, host_addr, host_wdata} = '0;
        tick();
        tick();
        #2 chk("reset_idle", all_out(), '0);
        core_req = 1'b1;
        host_req = 1'b1;
        #1 chk("reset_gated", all_out(), '0);
        tick();
        {core_req, host_req} = '0;
        reset = 1'b1;
        #2 chk("post_reset", all_out(), '0);

        // core store
        tick();
        core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hA5;
        push(0, 0);
        #2 chk("st_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h10, 32'hA5});
        chk("st_ack", {core_ack, core_stall, busy}, 3'b100);

        // core load
        tick();
        core_we = 0; core_addr = 32'h20;
        push(0, 32'h1234);
        #2 chk("ld_issue", {mem_en, mem_we, core_stall, core_ack, busy}, 5'b10100);
        tick();
        #2 chk("ld_ack", {core_ack, core_stall, busy, mem_en}, 4'b1010);
        tick();
        core_req = 0;
        #2 chk("ld_done", busy, 1'b0);

        // simultaneous writes
        tick();
        core_req = 1; core_we = 1; core_addr = 32'h4; core_wdata = 32'h11;
        host_req = 1; host_we = 1; host_addr = 32'h8; host_wdata = 32'h22;
        push(0, 0);
        push(1, 0);
        #2 chk("sim_core", {core_ack, host_ack, mem_addr}, {1'b1, 1'b0, 32'h4});
        tick();
        core_req = 0;
        #2 chk("sim_host", {host_ack, mem_en, mem_addr}, {1'b1, 1'b1, 32'h8});
        tick();
        host_req = 0;

        // starvation: four core grants then a forced host grant, twice
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 5; i++) begin
                tick();
                host_req = 1; host_we = 1;
                host_addr = r ? 32'h18 : 32'hC; host_wdata = r ? 32'h44 : 32'h33;
                core_req = 1; core_we = 1; core_addr = 32'h14; core_wdata = 32'h100 + 32'(r * 8 + i);
                if (i < 4) push(0, 0); else push(1, 0);
                #2;
                if (i < 4) chk("starve_core", {core_ack, host_ack, core_stall}, 3'b100);
                else chk("starve_host", {core_ack, host_ack, core_stall}, 3'b011);
            end
        tick();
        core_req = 0; host_req = 0;

        // host read then core load
        tick();
        host_req = 1; host_we = 0; host_addr = 32'h40;
        push(1, 32'hBEEF);
        #2 chk("hr_issue", {host_ack, mem_en, mem_we, busy}, 4'b0100);
        tick();
        core_req = 1; core_we = 0; core_addr = 32'h24;
        push(0, 32'h5678);
        #2 chk("hr_ack", {host_ack, core_stall, mem_en, busy}, 4'b1101);
        chk("hr_rdata", host_rdata, 32'hBEEF);
        tick();
        host_req = 0;
        #2 chk("cl_issue", {mem_en, mem_addr, core_stall}, {1'b1, 32'h24, 1'b1});
        tick();
        #2 chk("cl_ack", {core_ack, core_rdata}, {1'b1, 32'h5678});
        tick();
        core_req = 0;

        // reset during RD_HOST
        tick();
        host_req = 1; host_we = 0; host_addr = 32'h40;
        push(1, 32'hBEEF);
        #2 chk("rr_issue", {mem_en, busy}, 2'b10);
        tick();
        reset = 0;
        #2 chk("rr_abort", all_out(), '0);
        tick();
        #2 chk("rr_hold", all_out(), '0);
        tick();
        reset = 1;
        #2 chk("rr_reissue", {mem_en, mem_we, mem_addr, host_ack}, {1'b1, 1'b0, 32'h40, 1'b0});
        tick();
        #2 chk("rr_ack", {host_ack, busy, host_rdata}, {1'b1, 1'b1, 32'hBEEF});
        tick();
        host_req = 0;
        tick();
        tick();

        chk("mem_10", mem[8'h10], 32'hA5);
        chk("mem_08", mem[8'h08], 32'h22);
        chk("mem_0c", mem[8'h0C], 32'h33);
        chk("mem_18", mem[8'h18], 32'h44);
        chk("mem_14", mem[8'h14], 32'h10B);
        chk("sb_drain", 160'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
